// File: rtl/uart_baud_ctrl.sv
// Baud-rate controller: programmable divisor -> 16x oversample tick and bit tick,
// with divisor updates committed only on tick boundaries. Optional: UART_BAUD_FRAC_EN.
module uart_baud_ctrl #(
  parameter int DIV_W = 16,
  parameter int OSR   = 16
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             cfg_en,
  input  logic             cfg_wr,
  input  logic [DIV_W-1:0] cfg_div,
`ifdef UART_BAUD_FRAC_EN
  input  logic [3:0]       cfg_frac,
`endif
  output logic             baud16_tick,
  output logic             bit_tick,
  output logic             cfg_ack,
  output logic             busy,
  output logic             running,
  output logic [DIV_W-1:0] div_active
);

  localparam int SUB_W = (OSR > 1) ? $clog2(OSR) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [SUB_W-1:0] SUB_ZERO = {SUB_W{1'b0}};
  localparam logic [SUB_W-1:0] SUB_ONE  = {{(SUB_W-1){1'b0}}, 1'b1};
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OSR - 1);

  // A fractional carry stretches the next period by one cycle.
  function automatic logic [DIV_W-1:0] period_load(input logic [DIV_W-1:0] div,
                                                   input logic             carry);
    if (carry) begin
      period_load = div;
    end else begin
      period_load = div - DIV_ONE;
    end
  endfunction

  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [SUB_W-1:0] sub_q, sub_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       frac_q, frac_d;
  logic [3:0]       pfrac_q, pfrac_d;
  logic [3:0]       acc_q, acc_d;
  logic             tick_q, tick_d;
  logic             bit_q, bit_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             run_q, run_d;

  logic [3:0]       frac_in_s;
  logic [3:0]       eff_frac_s;
  logic [3:0]       use_frac_s;
  logic [4:0]       acc_sum_s;
  logic [DIV_W-1:0] eff_div_s;
  logic             boundary_s;

`ifdef UART_BAUD_FRAC_EN
  assign frac_in_s = cfg_frac;
`else
  assign frac_in_s = 4'd0;
`endif

  // An IDLE write is visible to the enable check in the same cycle.
  assign eff_div_s  = cfg_wr ? cfg_div : div_q;
  assign eff_frac_s = cfg_wr ? frac_in_s : frac_q;
  assign use_frac_s = (state_q == ST_PEND) ? pfrac_q : frac_q;
  assign acc_sum_s  = {1'b0, acc_q} + {1'b0, use_frac_s};
  assign boundary_s = (cnt_q == DIV_ZERO);

  // Next-state logic for the FSM, counters and divisor registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sub_d   = sub_q;
    pend_d  = pend_q;
    pfrac_d = pfrac_q;
    div_d   = div_q;
    frac_d  = frac_q;
    acc_d   = acc_q;
    tick_d  = 1'b0;
    bit_d   = 1'b0;
    ack_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        div_d  = eff_div_s;
        frac_d = eff_frac_s;
        ack_d  = cfg_wr;
        sub_d  = SUB_ZERO;
        acc_d  = 4'd0;
        if (cfg_en && (eff_div_s != DIV_ZERO)) begin
          state_d = ST_RUN;
          cnt_d   = eff_div_s - DIV_ONE;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = DIV_ZERO;
        end
      end

      ST_RUN, ST_PEND: begin
        if (!cfg_en) begin
          // Disable: flush any pending divisor, no tick on this edge.
          state_d = ST_IDLE;
          cnt_d   = DIV_ZERO;
          sub_d   = SUB_ZERO;
          acc_d   = 4'd0;
          if (cfg_wr) begin
            div_d  = cfg_div;
            frac_d = frac_in_s;
            ack_d  = 1'b1;
          end else if (state_q == ST_PEND) begin
            div_d  = pend_q;
            frac_d = pfrac_q;
            ack_d  = 1'b1;
          end else begin
            ack_d  = 1'b0;
          end
        end else begin
          if (boundary_s) begin
            tick_d = 1'b1;
            bit_d  = (sub_q == SUB_LAST);
            sub_d  = sub_q + SUB_ONE;
            acc_d  = acc_sum_s[3:0];
            if (state_q == ST_PEND) begin
              div_d  = pend_q;
              frac_d = pfrac_q;
              ack_d  = 1'b1;
              if (pend_q == DIV_ZERO) begin
                state_d = ST_IDLE;
                cnt_d   = DIV_ZERO;
                sub_d   = SUB_ZERO;
                acc_d   = 4'd0;
              end else begin
                state_d = ST_RUN;
                cnt_d   = period_load(pend_q, acc_sum_s[4]);
              end
            end else begin
              cnt_d = period_load(div_q, acc_sum_s[4]);
            end
          end else begin
            cnt_d = cnt_q - DIV_ONE;
          end

          // A write landing on a boundary is held for the following boundary.
          if (cfg_wr) begin
            if (state_d == ST_IDLE) begin
              div_d  = cfg_div;
              frac_d = frac_in_s;
            end else begin
              pend_d  = cfg_div;
              pfrac_d = frac_in_s;
              state_d = ST_PEND;
            end
          end else begin
            pend_d = pend_q;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = DIV_ZERO;
        sub_d   = SUB_ZERO;
        acc_d   = 4'd0;
      end
    endcase

    busy_d = (state_d == ST_PEND);
    run_d  = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= DIV_ZERO;
      sub_q   <= SUB_ZERO;
      pend_q  <= DIV_ZERO;
      pfrac_q <= 4'd0;
      div_q   <= DIV_ZERO;
      frac_q  <= 4'd0;
      acc_q   <= 4'd0;
      tick_q  <= 1'b0;
      bit_q   <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sub_q   <= sub_d;
      pend_q  <= pend_d;
      pfrac_q <= pfrac_d;
      div_q   <= div_d;
      frac_q  <= frac_d;
      acc_q   <= acc_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      run_q   <= run_d;
    end
  end

  assign baud16_tick = tick_q;
  assign bit_tick    = bit_q;
  assign cfg_ack     = ack_q;
  assign busy        = busy_q;
  assign running     = run_q;
  assign div_active  = div_q;

endmodule
